// File: rtl/gpmc_frame_packer.sv
// Round-robin packer: merges per-channel 18-bit {eof,sof,data} line streams into 36-bit
// {occ,eof,sof,data} words, two lines per word. Define GPMC_PACK_STATS_EN to enable frame_count.
module gpmc_frame_packer #(
    parameter int NUM_CHAN = 4,
    parameter int CHAN_W   = 2,
    parameter int LE       = 1
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   clear,
    input  logic [NUM_CHAN*18-1:0] in_data,
    input  logic [NUM_CHAN-1:0]    in_src_rdy,
    output logic [NUM_CHAN-1:0]    in_dst_rdy,
    output logic [35:0]            out_data,
    output logic [CHAN_W-1:0]      out_chan,
    output logic                   out_src_rdy,
    input  logic                   out_dst_rdy,
    output logic [31:0]            frame_count
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t            state;
    logic [CHAN_W-1:0] grant;
    logic [CHAN_W-1:0] rr_ptr;
    logic [CHAN_W-1:0] req_idx;
    logic [CHAN_W-1:0] cand;
    logic [CHAN_W-1:0] next_ptr;
    logic              req_found;
    logic [15:0]       half_data;
    logic              half_sof;
    logic [17:0]       line;
    logic              out_free;
    logic              take;
    logic [31:0]       word_pair;
    logic [31:0]       word_single;

    assign line     = in_data[32'(grant)*18 +: 18];
    assign out_free = !out_src_rdy || out_dst_rdy;
    assign take     = (state != IDLE) && out_free && in_src_rdy[grant];

    assign word_pair   = (LE != 0) ? {line[15:0], half_data} : {half_data, line[15:0]};
    assign word_single = (LE != 0) ? {16'h0000, line[15:0]} : {line[15:0], 16'h0000};

    // First requester at or after rr_ptr, wrapping modulo NUM_CHAN.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            cand = CHAN_W'((32'(rr_ptr) + i) % NUM_CHAN);
            if (!req_found && in_src_rdy[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    assign next_ptr = CHAN_W'((32'(req_idx) + 32'd1) % NUM_CHAN);

    always_comb begin
        in_dst_rdy = '0;
        if (state != IDLE && out_free)
            in_dst_rdy[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            half_data   <= '0;
            half_sof    <= 1'b0;
            out_data    <= '0;
            out_chan    <= '0;
            out_src_rdy <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            half_data   <= '0;
            half_sof    <= 1'b0;
            out_src_rdy <= 1'b0;
        end else begin
            if (out_src_rdy && out_dst_rdy)
                out_src_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_found) begin
                        grant  <= req_idx;
                        rr_ptr <= next_ptr;
                        state  <= LOW;
                    end
                end
                LOW: begin
                    if (take) begin
                        if (line[17]) begin
                            // eof on the first half: emit a half-filled word
                            out_data    <= {2'd2, 1'b1, line[16], word_single};
                            out_chan    <= grant;
                            out_src_rdy <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            half_data <= line[15:0];
                            half_sof  <= line[16];
                            state     <= HIGH;
                        end
                    end
                end
                HIGH: begin
                    if (take) begin
                        out_data    <= {2'd0, line[17], half_sof, word_pair};
                        out_chan    <= grant;
                        out_src_rdy <= 1'b1;
                        state       <= line[17] ? IDLE : LOW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GPMC_PACK_STATS_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            frame_count <= '0;
        else if (clear)
            frame_count <= '0;
        else if (out_src_rdy && out_dst_rdy && out_data[33])
            frame_count <= frame_count + 32'd1;
    end
`else
    assign frame_count = '0;
`endif

endmodule
